// File: rtl/seq_ser_gen_if.sv
// Load handshake and serial output bundle for the pattern serializer.
`timescale 1ns/1ps
interface seq_ser_gen_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [CNT_W-1:0] reps;
    logic [CNT_W-1:0] gap;
    logic             ser_out;
    logic             ser_valid;
    logic             pat_end;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, pattern, pat_len, reps, gap,
        input  load_ready, ser_out, ser_valid, pat_end, busy, done
    );

    modport slave (
        input  load_valid, pattern, pat_len, reps, gap,
        output load_ready, ser_out, ser_valid, pat_end, busy, done
    );
endinterface

// File: rtl/seq_ser_gen.sv
// Serializes a latched parallel pattern MSB-first, repeating it a
// programmable number of times with an optional idle gap in between.
`timescale 1ns/1ps
module seq_ser_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_ser_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [LEN_W-1:0] idx;

    logic ser_out_r, ser_valid_r, pat_end_r, busy_r, done_r, ready_r;

    logic [LEN_W-1:0] ld_len;
    logic [CNT_W-1:0] ld_reps;
    logic [LEN_W-1:0] idx_nxt;
    logic             last_bit;

    // Bit at position pos of the transmit order (pos 0 is bit len-1).
    function automatic logic bit_at(input logic [WIDTH-1:0] pat,
                                    input logic [LEN_W-1:0] len,
                                    input logic [LEN_W-1:0] pos);
        logic [LEN_W-1:0] sel;
        logic [WIDTH-1:0] tmp;
        sel = len - ONE_L - pos;
        tmp = pat >> sel;
        return tmp[0];
    endfunction

    // Load-time field normalisation and bit-index helpers.
    always_comb begin
        ld_len   = bus.pat_len;
        ld_reps  = bus.reps;
        if (bus.pat_len == '0 || bus.pat_len > WIDTH_L) ld_len = WIDTH_L;
        if (bus.reps == '0) ld_reps = ONE_C;
        idx_nxt  = idx + ONE_L;
        last_bit = (idx == len_r - ONE_L);
    end

    // Control FSM with registered outputs; latched fields are not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            pat_end_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ready_r     <= 1'b1;
            idx         <= '0;
            gap_cnt     <= '0;
            rep_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r      <= 1'b0;
                    ser_out_r   <= 1'b0;
                    ser_valid_r <= 1'b0;
                    pat_end_r   <= 1'b0;
                    if (bus.load_valid && ready_r) begin
                        pat_r       <= bus.pattern;
                        len_r       <= ld_len;
                        gap_r       <= bus.gap;
                        rep_cnt     <= ld_reps;
                        idx         <= '0;
                        state       <= SHIFT;
                        ser_out_r   <= bit_at(bus.pattern, ld_len, '0);
                        ser_valid_r <= 1'b1;
                        pat_end_r   <= (ld_len == ONE_L);
                        busy_r      <= 1'b1;
                        ready_r     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        if (rep_cnt == ONE_C) begin
                            state       <= IDLE;
                            ser_out_r   <= 1'b0;
                            ser_valid_r <= 1'b0;
                            pat_end_r   <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            ready_r     <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt - ONE_C;
                            if (gap_r != '0) begin
                                state       <= GAP;
                                gap_cnt     <= ONE_C;
                                ser_out_r   <= 1'b0;
                                ser_valid_r <= 1'b0;
                                pat_end_r   <= 1'b0;
                            end else begin
                                // Zero gap: next repetition follows with no bubble.
                                idx         <= '0;
                                ser_out_r   <= bit_at(pat_r, len_r, '0);
                                ser_valid_r <= 1'b1;
                                pat_end_r   <= (len_r == ONE_L);
                            end
                        end
                    end else begin
                        idx         <= idx_nxt;
                        ser_out_r   <= bit_at(pat_r, len_r, idx_nxt);
                        ser_valid_r <= 1'b1;
                        pat_end_r   <= (idx_nxt == len_r - ONE_L);
                    end
                end
                GAP: begin
                    // gap_cnt numbers the idle cycle currently on the line.
                    if (gap_cnt == gap_r) begin
                        state       <= SHIFT;
                        idx         <= '0;
                        ser_out_r   <= bit_at(pat_r, len_r, '0);
                        ser_valid_r <= 1'b1;
                        pat_end_r   <= (len_r == ONE_L);
                    end else begin
                        gap_cnt <= gap_cnt + ONE_C;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ser_out    = ser_out_r;
    assign bus.ser_valid  = ser_valid_r;
    assign bus.pat_end    = pat_end_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.load_ready = ready_r;
endmodule

// File: tb/tb_seq_ser_gen.sv
// Self-checking bench for seq_ser_gen: table vectors, corner sequences
// and randomized transmissions against a stream-level reference model.
`timescale 1ns/1ps
module tb_seq_ser_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_ser_gen_if #(.WIDTH(8), .LEN_W(4), .CNT_W(8)) bus ();

    seq_ser_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output vector order: {ser_out, ser_valid, pat_end, busy, done, load_ready}
    localparam logic [5:0] IDLE_V = 6'b000001;

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  pat_len;
        logic [7:0]  reps;
        logic [7:0]  gap;
        int          exp_cycles;
        logic [31:0] exp_bits;
        int          exp_nbits;
        int          exp_pends;
    } vec_t;

    vec_t tbl [6];

    logic [5:0]  exp_q [$];
    logic [31:0] got_bits;
    int          got_nbits, got_pends, got_cycles;

    function automatic logic [5:0] sample();
        return {bus.ser_out, bus.ser_valid, bus.pat_end, bus.busy, bus.done, bus.load_ready};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%b want=%b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, expv);
        end
    endtask

    // Expected per-cycle outputs from the first bit through the done cycle.
    function automatic void build_model(input logic [7:0] p, input logic [3:0] l,
                                        input logic [7:0] r, input logic [7:0] g);
        int len, nrep;
        exp_q.delete();
        len  = (l == 0 || l > 8) ? 8 : int'(l);
        nrep = (r == 0) ? 1 : int'(r);
        for (int rr = 0; rr < nrep; rr++) begin
            for (int i = 0; i < len; i++)
                exp_q.push_back({p[len-1-i], 1'b1, (i == len-1), 1'b1, 1'b0, 1'b0});
            if (rr < nrep - 1)
                for (int j = 0; j < int'(g); j++)
                    exp_q.push_back(6'b000100);
        end
        exp_q.push_back(6'b000011);
    endfunction

    // Compare from the current sample point (first bit) through the done cycle.
    task automatic check_stream(input string name);
        logic [5:0] act;
        got_bits = '0; got_nbits = 0; got_pends = 0; got_cycles = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            act = sample();
            chk(name, act, exp_q[i]);
            if (act[4]) begin
                got_bits = {got_bits[30:0], act[5]};
                got_nbits++;
            end
            if (act[3]) got_pends++;
            if (act[2]) got_cycles++;
            if (i < exp_q.size() - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drive(input logic [7:0] p, input logic [3:0] l,
                         input logic [7:0] r, input logic [7:0] g);
        bus.pattern = p; bus.pat_len = l; bus.reps = r; bus.gap = g;
    endtask

    task automatic run_tx(input string name, input logic [7:0] p, input logic [3:0] l,
                          input logic [7:0] r, input logic [7:0] g);
        drive(p, l, r, g);
        bus.load_valid = 1'b1;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        build_model(p, l, r, g);
        check_stream(name);
    endtask

    task automatic idle_cycle(input string name);
        @(posedge clk); #1;
        chk(name, sample(), IDLE_V);
    endtask

    initial begin
        tbl[0] = '{8'h0B, 4'd4, 8'd1, 8'd0, 4,  32'hB,   4,  1};
        tbl[1] = '{8'h0B, 4'd4, 8'd3, 8'd2, 16, 32'hBBB, 12, 3};
        tbl[2] = '{8'h06, 4'd3, 8'd2, 8'd0, 6,  32'h36,  6,  2};
        tbl[3] = '{8'hA5, 4'd0, 8'd0, 8'd0, 8,  32'hA5,  8,  1};
        tbl[4] = '{8'h3C, 4'd9, 8'd1, 8'd1, 8,  32'h3C,  8,  1};
        tbl[5] = '{8'h01, 4'd1, 8'd3, 8'd1, 5,  32'h7,   3,  3};

        bus.load_valid = 1'b0;
        drive(8'h00, 4'd0, 8'd0, 8'd0);

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", sample(), IDLE_V);
        rst = 1'b1;
        idle_cycle("post_reset_idle");

        // Table vectors
        for (int t = 0; t < 6; t++) begin
            run_tx($sformatf("tbl%0d", t), tbl[t].pattern, tbl[t].pat_len,
                   tbl[t].reps, tbl[t].gap);
            chk_int($sformatf("tbl%0d_cycles", t), got_cycles, tbl[t].exp_cycles);
            chk_int($sformatf("tbl%0d_nbits", t), got_nbits, tbl[t].exp_nbits);
            chk_int($sformatf("tbl%0d_bits", t), int'(got_bits), int'(tbl[t].exp_bits));
            chk_int($sformatf("tbl%0d_pends", t), got_pends, tbl[t].exp_pends);
            idle_cycle($sformatf("tbl%0d_after", t));
        end

        // Reset during the second bit aborts without a done pulse
        drive(8'h0B, 4'd4, 8'd1, 8'd0);
        bus.load_valid = 1'b1;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        chk("abort_bit1", sample(), 6'b110100);
        @(posedge clk); #1;
        chk("abort_bit2", sample(), 6'b010100);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_reset", sample(), IDLE_V);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) idle_cycle("abort_no_done");
        run_tx("after_abort", 8'h0B, 4'd4, 8'd2, 8'd1);

        // Load held high with a different pattern during a transmission
        drive(8'h0B, 4'd4, 8'd2, 8'd1);
        bus.load_valid = 1'b1;
        @(posedge clk); #1;
        drive(8'h05, 4'd3, 8'd1, 8'd3);
        build_model(8'h0B, 4'd4, 8'd2, 8'd1);
        check_stream("held_first");
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        build_model(8'h05, 4'd3, 8'd1, 8'd3);
        check_stream("held_second");

        // Back-to-back: new load issued in the done cycle
        run_tx("b2b_a", 8'hC3, 4'd8, 8'd1, 8'd0);
        run_tx("b2b_b", 8'h5A, 4'd5, 8'd2, 8'd0);
        idle_cycle("b2b_after");

        // Randomized transmissions
        for (int n = 0; n < 30; n++) begin
            logic [7:0] p, r, g;
            logic [3:0] l;
            int         pre;
            p   = 8'($urandom);
            l   = 4'($urandom_range(0, 9));
            r   = 8'($urandom_range(0, 3));
            g   = 8'($urandom_range(0, 3));
            pre = $urandom_range(0, 2);
            for (int k = 0; k < pre; k++) idle_cycle("rand_idle");
            run_tx($sformatf("rand%0d", n), p, l, r, g);
        end
        idle_cycle("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_ser_gen.md
Name: seq_ser_gen

Overview:
Transmit-side counterpart of the serial sequence detector (seq_det). Accepts a parallel bit pattern with a valid/ready load handshake and serializes it MSB-first onto a 1-bit line. The pattern can repeat a programmable number of times, with a programmable idle gap between repetitions. Used as the stimulus source for seq_det, and as a standalone pattern transmitter for serial links in the design.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of pat_len field; must hold WIDTH
CNT_W, 8, width of repeat and gap counters

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
load_valid  input  1  request to start a new transmission
load_ready  output  1  block idle and able to accept a load
pattern  input  WIDTH  pattern bits; bit pat_len-1 is sent first
pat_len  input  LEN_W  number of pattern bits to send
reps  input  CNT_W  number of repetitions
gap  input  CNT_W  idle cycles between repetitions
ser_out  output  1  serial data
ser_valid  output  1  ser_out carries a pattern bit this cycle
pat_end  output  1  high with the last bit of each repetition
busy  output  1  transmission in progress (SHIFT or GAP)
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE.
  - ser_out=0, ser_valid=0, pat_end=0, busy=0, done=0, load_ready=1.
  - Reset mid-transmission aborts immediately: no done pulse, and the partial pattern is discarded.
- All outputs are registered. load_ready=1 exactly when state==IDLE.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - ser_out=0, ser_valid=0.
  - On an edge with load_valid&&load_ready, latch pattern, pat_len, reps and gap, then go to SHIFT.
  - Field normalisation at latch time:
    - pat_len==0 or pat_len>WIDTH is treated as WIDTH.
    - reps==0 is treated as 1.
- Latency: a load accepted at edge k makes the first bit visible on ser_out/ser_valid in the cycle after edge k.
- SHIFT:
  - Each cycle drives ser_out=pattern[len-1-idx] with ser_valid=1; idx counts 0..len-1.
  - pat_end=1 only when idx==len-1.
- After the last bit of a repetition:
  - If repetitions remain and gap>0: go to GAP.
  - If repetitions remain and gap==0: restart SHIFT at idx=0 in the next cycle (contiguous stream).
  - If this was the final repetition: go to IDLE, with done=1 and load_ready=1 in that next cycle.
- GAP:
  - ser_out=0, ser_valid=0 for exactly gap cycles, then SHIFT with idx=0.
- busy=1 in SHIFT and GAP, 0 in IDLE.
- Total cycles from first bit to last bit = reps*len + (reps-1)*gap.
- load_valid while busy is ignored; latched fields are unaffected.
- Back-to-back loads: a load accepted in the done cycle is legal. Its first bit appears the next cycle, so there is no extra idle cycle beyond the done cycle.
- Repeat counter counts down from the latched reps. Reaching 1 at pat_end marks the final repetition; there is no wrap-around.
- No arithmetic overflow: idx is LEN_W bits and the gap counter is CNT_W bits, each compared against latched values.

Test Plan:
- WIDTH=8, pattern=8'b0000_1011, pat_len=4, reps=1, gap=0 → ser_out=1,0,1,1 over 4 consecutive cycles starting the cycle after the handshake; ser_valid=1 for all 4; pat_end only on the 4th; done=1 on the 5th with load_ready=1.
- Same pattern, reps=3, gap=2 → valid-bit stream 1011,--,1011,--,1011 across 16 cycles; ser_valid=0 and ser_out=0 in the 4 gap cycles; pat_end pulses 3 times; busy high all 16 cycles; single done after.
- pattern=3'b110, pat_len=3, reps=2, gap=0 → contiguous 1,1,0,1,1,0 with no ser_valid drop; pat_end on cycles 3 and 6. Feeding this stream into seq_det yields det_out consistent with that detector's sequence.
- pat_len=0, reps=0, pattern=8'hA5 → treated as len=8, reps=1: 1,0,1,0,0,1,0,1 then done.
- rst driven low during the 2nd bit of a 4-bit pattern → at the next edge ser_out=0, ser_valid=0, busy=0, load_ready=1; no done pulse. A new load is accepted after rst returns high.
- load_valid held high with a different pattern throughout a transmission → ignored until the done cycle, accepted there, and its first bit appears in the following cycle.
